// File: rtl/scroll_engine.sv
// scroll_engine: scrolls a row region of the console text RAM up or down,
// copying cells through a 1-cycle-latency read port and blanking vacated rows.
`ifndef CONSOLE_LINES
`define CONSOLE_LINES 25
`endif
`ifndef CONSOLE_COLUMNS
`define CONSOLE_COLUMNS 80
`endif

package scroll_pkg;
    typedef struct packed {
        logic       dir;
        logic [7:0] step;
        logic [7:0] top;
        logic [7:0] bottom;
        logic       reset;
    } Scrolling_t;
endpackage

module scroll_engine
    import scroll_pkg::*;
#(
    parameter int                LINES   = `CONSOLE_LINES,
    parameter int                COLUMNS = `CONSOLE_COLUMNS,
    parameter int                CELL_W  = 16,
    parameter logic [CELL_W-1:0] BLANK   = 16'h0020
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  Scrolling_t        scrolling,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rd_row,
    output logic [7:0]        rd_col,
    input  logic [CELL_W-1:0] rd_data,
    output logic              wr_en,
    output logic [7:0]        wr_row,
    output logic [7:0]        wr_col,
    output logic [CELL_W-1:0] wr_data
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        COPY,
        DRAIN,
        FILL,
        DONE
    } state_t;

    localparam logic [7:0] COL_LAST = 8'(COLUMNS - 1);

    state_t            state;
    Scrolling_t        req;
    logic [7:0]        cur_row;
    logic [7:0]        copy_last;
    logic [7:0]        fill_row;
    logic [7:0]        fill_last;
    logic              wr_copy;
    logic [CELL_W-1:0] wr_fill;

    logic [7:0] span;
    logic [7:0] n_c;
    logic       noop;
    logic [7:0] dst_first;
    logic [7:0] src_first;
    logic [7:0] dst_last;
    logic [7:0] fill_first;
    logic [7:0] fill_end;

    // Region geometry derived from the latched request during SETUP
    always_comb begin
        span = req.bottom - req.top + 8'd1;
        n_c  = (req.step < span) ? req.step : span;
        noop = req.reset
            || (req.step == 8'd0)
            || (req.top > req.bottom)
            || (int'(req.bottom) >= LINES);
        if (req.dir) begin
            dst_first  = req.top;
            src_first  = req.top + n_c;
            dst_last   = req.bottom - n_c;
            fill_first = req.bottom - n_c + 8'd1;
            fill_end   = req.bottom;
        end else begin
            dst_first  = req.bottom;
            src_first  = req.bottom - n_c;
            dst_last   = req.top + n_c;
            fill_first = req.top;
            fill_end   = req.top + n_c - 8'd1;
        end
    end

    // Copy writes forward the read data arriving this cycle
    assign wr_data = wr_copy ? rd_data : wr_fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_row    <= 8'd0;
            rd_col    <= 8'd0;
            wr_en     <= 1'b0;
            wr_row    <= 8'd0;
            wr_col    <= 8'd0;
            wr_copy   <= 1'b0;
            wr_fill   <= '0;
            cur_row   <= 8'd0;
            copy_last <= 8'd0;
            fill_row  <= 8'd0;
            fill_last <= 8'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    wr_en <= 1'b0;
                    if (start) begin
                        req   <= scrolling;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (noop) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        copy_last <= dst_last;
                        fill_row  <= fill_first;
                        fill_last <= fill_end;
                        if (n_c == span) begin
                            wr_en   <= 1'b1;
                            wr_copy <= 1'b0;
                            wr_fill <= BLANK;
                            wr_row  <= fill_first;
                            wr_col  <= 8'd0;
                            state   <= FILL;
                        end else begin
                            cur_row <= dst_first;
                            rd_row  <= src_first;
                            rd_col  <= 8'd0;
                            state   <= COPY;
                        end
                    end
                end
                COPY: begin
                    wr_en   <= 1'b1;
                    wr_copy <= 1'b1;
                    wr_row  <= cur_row;
                    wr_col  <= rd_col;
                    if (rd_col == COL_LAST) begin
                        if (cur_row == copy_last) begin
                            state <= DRAIN;
                        end else begin
                            rd_col <= 8'd0;
                            if (req.dir) begin
                                cur_row <= cur_row + 8'd1;
                                rd_row  <= rd_row + 8'd1;
                            end else begin
                                cur_row <= cur_row - 8'd1;
                                rd_row  <= rd_row - 8'd1;
                            end
                        end
                    end else begin
                        rd_col <= rd_col + 8'd1;
                    end
                end
                DRAIN: begin
                    wr_en   <= 1'b1;
                    wr_copy <= 1'b0;
                    wr_fill <= BLANK;
                    wr_row  <= fill_row;
                    wr_col  <= 8'd0;
                    state   <= FILL;
                end
                FILL: begin
                    if (wr_col == COL_LAST) begin
                        if (wr_row == fill_last) begin
                            wr_en <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            wr_row <= wr_row + 8'd1;
                            wr_col <= 8'd0;
                        end
                    end else begin
                        wr_col <= wr_col + 8'd1;
                    end
                end
                DONE: begin
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scroll_engine.sv
// tb_scroll_engine: directed table plus randomized scrolls checked against
// a whole-screen reference model and a behavioural text RAM.
module tb_scroll_engine;
    import scroll_pkg::*;

    localparam int          LINES = 8;
    localparam int          COLS  = 4;
    localparam logic [15:0] BLANK = 16'h0020;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    Scrolling_t  scrolling;
    logic        busy;
    logic        done;
    logic [7:0]  rd_row;
    logic [7:0]  rd_col;
    logic [15:0] rd_data;
    logic        wr_en;
    logic [7:0]  wr_row;
    logic [7:0]  wr_col;
    logic [15:0] wr_data;

    always #5 clk = ~clk;

    scroll_engine #(
        .LINES   (LINES),
        .COLUMNS (COLS),
        .CELL_W  (16),
        .BLANK   (BLANK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .scrolling (scrolling),
        .busy      (busy),
        .done      (done),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data)
    );

    logic [15:0] mem      [LINES][COLS];
    logic [15:0] init_mem [LINES][COLS];
    logic [15:0] exp_mem  [LINES][COLS];
    logic        load = 1'b0;
    int          cyc_ctr = 0;

    typedef struct {
        int cyc;
        int row;
        int col;
    } wrec_t;
    wrec_t wlog[$];

    // Text RAM: synchronous read with one cycle latency
    always @(posedge clk) begin
        if (load) mem <= init_mem;
        else if (wr_en && wr_row < LINES && wr_col < COLS)
            mem[wr_row][wr_col] <= wr_data;
        if (rd_row < LINES && rd_col < COLS)
            rd_data <= mem[rd_row][rd_col];
        else
            rd_data <= 16'hdead;
        if (wr_en) wlog.push_back('{cyc_ctr, int'(wr_row), int'(wr_col)});
        cyc_ctr <= cyc_ctr + 1;
    end

    int n_pass = 0;
    int n_chk  = 0;

    function automatic void chk(string name, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endfunction

    function automatic Scrolling_t mk(logic d, int st, int tp, int bt, logic rs);
        Scrolling_t s;
        s.dir    = d;
        s.step   = 8'(st);
        s.top    = 8'(tp);
        s.bottom = 8'(bt);
        s.reset  = rs;
        return s;
    endfunction

    function automatic void set_pattern();
        for (int r = 0; r < LINES; r++)
            for (int c = 0; c < COLS; c++)
                init_mem[r][c] = 16'(r * 256 + c);
    endfunction

    function automatic void set_random();
        for (int r = 0; r < LINES; r++)
            for (int c = 0; c < COLS; c++)
                init_mem[r][c] = 16'($urandom);
    endfunction

    // Screen-level model: each region row takes the row n away, else blank
    function automatic void model(input Scrolling_t sc, output int e_done,
                                  output int e_wr, output int e_first);
        int  tp, bt, rc, n, src;
        logic noop;
        tp = int'(sc.top);
        bt = int'(sc.bottom);
        noop = sc.reset || sc.step == 0 || tp > bt || bt >= LINES;
        exp_mem = init_mem;
        if (noop) begin
            e_done  = 2;
            e_wr    = 0;
            e_first = -1;
            return;
        end
        rc = bt - tp + 1;
        n  = (int'(sc.step) < rc) ? int'(sc.step) : rc;
        e_done  = 1 + (rc - n) * COLS + (rc > n ? 1 : 0) + n * COLS + 1;
        e_wr    = rc * COLS;
        e_first = (rc > n) ? 3 : 2;
        for (int r = tp; r <= bt; r++) begin
            src = sc.dir ? r + n : r - n;
            for (int c = 0; c < COLS; c++)
                exp_mem[r][c] = (src >= tp && src <= bt) ? init_mem[src][c] : BLANK;
        end
    endfunction

    function automatic int mem_diff();
        int d = 0;
        for (int r = 0; r < LINES; r++)
            for (int c = 0; c < COLS; c++)
                if (mem[r][c] !== exp_mem[r][c]) d++;
        return d;
    endfunction

    task automatic load_mem();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run(input Scrolling_t sc, input int extra_at,
                       input Scrolling_t extra,
                       output int done_cyc, output int ndone,
                       output int busy_after, output int nwr,
                       output int first_wr, output int last_wr,
                       output int oob);
        int k, base, idx, c;
        @(negedge clk);
        base = cyc_ctr;
        idx = wlog.size();
        scrolling = sc;
        start = 1'b1;
        k = 0;
        done_cyc = -1;
        ndone = 0;
        busy_after = -1;
        while (k < 400 && !(done_cyc >= 0 && k >= done_cyc + 25)) begin
            @(negedge clk);
            k++;
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (done_cyc >= 0 && k == done_cyc + 1) busy_after = int'(busy);
            start = (k == extra_at);
            scrolling = start ? extra : sc;
        end
        start = 1'b0;
        nwr = 0;
        first_wr = -1;
        last_wr = -1;
        oob = 0;
        for (int i = idx; i < wlog.size(); i++) begin
            c = wlog[i].cyc - base;
            nwr++;
            if (first_wr < 0) first_wr = c;
            last_wr = c;
            if (wlog[i].row < int'(sc.top) || wlog[i].row > int'(sc.bottom)
                || wlog[i].col >= COLS) oob++;
        end
    endtask

    // tbl_done < 0 selects the model's timing instead of a table constant
    task automatic check_vec(input string tag, input Scrolling_t sc,
                             input int tbl_done, input int tbl_wr,
                             input int extra_at, input Scrolling_t extra);
        int e_done, e_wr, e_first;
        int d_cyc, nd, ba, nw, fw, lw, oob;
        model(sc, e_done, e_wr, e_first);
        if (tbl_done >= 0) begin
            e_done = tbl_done;
            e_wr   = tbl_wr;
        end
        load_mem();
        run(sc, extra_at, extra, d_cyc, nd, ba, nw, fw, lw, oob);
        chk({tag, " done_cycle"}, d_cyc, e_done);
        chk({tag, " done_count"}, nd, 1);
        chk({tag, " busy_after_done"}, ba, 0);
        chk({tag, " writes"}, nw, e_wr);
        chk({tag, " first_write"}, fw, e_first);
        chk({tag, " last_write"}, lw, (e_wr > 0) ? e_done - 1 : -1);
        chk({tag, " out_of_region"}, oob, 0);
        chk({tag, " mem_cells_wrong"}, mem_diff(), 0);
    endtask

    typedef struct {
        Scrolling_t sc;
        int         exp_done;
        int         exp_wr;
    } vec_t;

    vec_t       vecs[9];
    Scrolling_t none;
    Scrolling_t sc;

    initial begin
        vecs[0] = '{mk(1'b1, 1, 0, 3, 1'b0), 19, 16};
        vecs[1] = '{mk(1'b0, 2, 0, 3, 1'b0), 19, 16};
        vecs[2] = '{mk(1'b1, 9, 0, 3, 1'b0), 18, 16};
        vecs[3] = '{mk(1'b1, 1, 0, 3, 1'b1),  2,  0};
        vecs[4] = '{mk(1'b0, 0, 0, 3, 1'b0),  2,  0};
        vecs[5] = '{mk(1'b1, 1, 5, 2, 1'b0),  2,  0};
        vecs[6] = '{mk(1'b1, 1, 2, 8, 1'b0),  2,  0};
        vecs[7] = '{mk(1'b1, 2, 2, 6, 1'b0), 23, 20};
        vecs[8] = '{mk(1'b0, 1, 7, 7, 1'b0),  6,  4};
        none = '0;

        rst = 1'b1;
        start = 1'b0;
        scrolling = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst wr_en", int'(wr_en), 0);
        chk("rst rd_row", int'(rd_row), 0);
        chk("rst rd_col", int'(rd_col), 0);
        chk("rst wr_row", int'(wr_row), 0);
        chk("rst wr_col", int'(wr_col), 0);
        chk("rst wr_data", int'(wr_data), 0);
        rst = 1'b0;
        @(negedge clk);

        set_pattern();
        for (int i = 0; i < 9; i++)
            check_vec($sformatf("vec%0d", i), vecs[i].sc,
                      vecs[i].exp_done, vecs[i].exp_wr, -1, none);

        // Start pulses while busy and during DONE must be dropped
        set_pattern();
        check_vec("start_mid", vecs[0].sc, 19, 16, 5, mk(1'b0, 1, 7, 7, 1'b0));
        check_vec("start_in_done", vecs[0].sc, 19, 16, 19,
                  mk(1'b0, 1, 7, 7, 1'b0));

        // Asynchronous reset in the middle of COPY
        set_pattern();
        load_mem();
        @(negedge clk);
        scrolling = vecs[0].sc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst wr_en", int'(wr_en), 1);
        chk("pre_rst busy", int'(busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst busy", int'(busy), 0);
        chk("async_rst wr_en", int'(wr_en), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst idle", int'(busy), 0);
        set_pattern();
        check_vec("after_rst", vecs[1].sc, 19, 16, -1, none);

        for (int i = 0; i < 25; i++) begin
            int tp;
            tp = $urandom_range(0, 7);
            sc = mk(1'($urandom_range(0, 1)), $urandom_range(0, 9), tp,
                    tp + $urandom_range(0, 8 - tp),
                    ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 7) == 0) sc.top = 8'($urandom_range(0, 7));
            set_random();
            check_vec($sformatf("rnd%0d", i), sc, -1, 0, -1, none);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/scroll_engine.md
SCROLL_ENGINE -- requirements
Module: scroll_engine

Interface
REQ-001 Parameter LINES, default `CONSOLE_LINES, screen rows.
REQ-002 Parameter COLUMNS, default `CONSOLE_COLUMNS, screen columns.
REQ-003 Parameter CELL_W, default 16, text-RAM cell width.
REQ-004 Parameter BLANK, default 16'h0020, fill value for vacated cells.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle request pulse from cursor control.
REQ-008 scrolling  in  Scrolling_t  dir (1=up, 0=down), step, top, bottom, reset; sampled when start accepted.
REQ-009 busy  out  1  engine not idle.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 rd_row/rd_col  out  8/8  text-RAM read address; read data valid exactly 1 cycle later.
REQ-012 rd_data  in  CELL_W  text-RAM read data.
REQ-013 wr_en  out  1  text-RAM write strobe.
REQ-014 wr_row/wr_col/wr_data  out  8/8/CELL_W  text-RAM write address and data.

Function
REQ-015 States: IDLE, SETUP, COPY, DRAIN, FILL, DONE.
REQ-016 In IDLE, start=1 latches scrolling into internal registers and moves to SETUP; start in any other state is ignored, with no queuing.
REQ-017 SETUP computes R = bottom-top+1 and n = MIN(step, R) at 8-bit width.
- No-op when reset=1, step=0, top>bottom or bottom>=LINES.
- A no-op goes SETUP->DONE with no RAM writes.
REQ-018 In COPY, up direction: for dst rows top..bottom-n ascending, columns 0..COLUMNS-1 ascending, read (dst+n, col).
REQ-019 In COPY, down direction: for dst rows bottom..top+n descending, columns ascending, read (dst-n, col).
REQ-020 Exactly one read is issued per COPY cycle, for (R-n)*COLUMNS cycles.
- Each cycle, rd_data from the previous cycle's read is written to its dst cell.
- COPY is skipped when R==n.
REQ-021 DRAIN lasts one cycle and performs the final copy write; it is entered only if COPY ran.
REQ-022 FILL writes BLANK to n*COLUMNS cells, one per cycle.
- Up direction: rows bottom-n+1..bottom.
- Down direction: rows top..top+n-1.
- Columns ascending.
REQ-023 DONE lasts one cycle with done=1, then returns to IDLE; a start in that DONE cycle is ignored.
REQ-024 busy=1 in every state except IDLE, including the DONE cycle.
REQ-025 wr_en=1 only on cycles that perform a copy or fill write; rows outside [top,bottom] are never written.
REQ-026 Row and column counters wrap only at region and COLUMNS bounds, never at 8-bit overflow.
REQ-027 Cycle count for a non-no-op, start at cycle 0: done at cycle 1 + (R-n)*COLUMNS + (R>n ? 1 : 0) + n*COLUMNS + 1.

Reset
REQ-028 rst=1 forces IDLE immediately, asynchronously, including mid-operation; a partial scroll is abandoned and not resumed.
REQ-029 Reset values: busy=0, done=0, wr_en=0, rd_row=0, rd_col=0, wr_row=0, wr_col=0, wr_data=0, latched request=0.

Verification
REQ-030 COLUMNS=4, top=0, bottom=3, up, step=1 with row r holding value r -> rows read 1,2,3,BLANK.
- SETUP at cycle 1, COPY cycles 2-13, DRAIN cycle 14, FILL cycles 15-18, done at cycle 19.
REQ-031 Same region, down, step=2 -> rows read BLANK,BLANK,0,1; rows outside 0..3 unchanged.
REQ-032 step=9 with R=4 -> n clamped to 4; no COPY or DRAIN; 16 BLANK writes; done at cycle 18.
REQ-033 scrolling.reset=1 or step=0 -> no wr_en; done at cycle 2.
REQ-034 Second start pulsed at cycle 5 of an active scroll -> ignored; exactly one done.
REQ-035 rst asserted at cycle 7 mid-COPY -> busy=0 and wr_en=0 immediately; a new start after release runs to completion.
